// File: rtl/conv_ser_pkg.sv
// Shared types and width helpers for the convolution output serializer.
package conv_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } conv_ser_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_K          = 6;
  localparam int DEF_OH         = 32;
  localparam int DEF_OW         = 32;

  // Index width for a dimension of size n; a dimension of 1 still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_idx_counter.sv
// Nested channel/row/column counter; column is the fastest-moving index.
module conv_idx_counter
  import conv_ser_pkg::*;
#(
  parameter int K  = DEF_K,
  parameter int OH = DEF_OH,
  parameter int OW = DEF_OW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 step,
  output logic [idx_w(K)-1:0]  chan,
  output logic [idx_w(OH)-1:0] row,
  output logic [idx_w(OW)-1:0] col,
  output logic                 last
);

  localparam int CW = idx_w(K);
  localparam int RW = idx_w(OH);
  localparam int LW = idx_w(OW);

  logic [CW-1:0] chan_q, chan_d;
  logic [RW-1:0] row_q, row_d;
  logic [LW-1:0] col_q, col_d;
  logic          col_wrap, row_wrap, chan_wrap;

  always_comb begin
    col_wrap  = (col_q == LW'(OW - 1));
    row_wrap  = (row_q == RW'(OH - 1));
    chan_wrap = (chan_q == CW'(K - 1));
    chan_d    = chan_q;
    row_d     = row_q;
    col_d     = col_q;
    if (clear) begin
      chan_d = '0;
      row_d  = '0;
      col_d  = '0;
    end else if (step) begin
      col_d = col_wrap ? '0 : col_q + LW'(1);
      if (col_wrap) begin
        row_d = row_wrap ? '0 : row_q + RW'(1);
        if (row_wrap) begin
          chan_d = chan_wrap ? '0 : chan_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      chan_q <= chan_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  assign chan = chan_q;
  assign row  = row_q;
  assign col  = col_q;
  assign last = col_wrap & row_wrap & chan_wrap;

endmodule

// File: rtl/conv_output_serializer.sv
// Captures a flat convolution result and streams it word by word over valid/ready.
// Optional ReLU clamp on output words is enabled by defining CONV_SER_RELU_EN.
module conv_output_serializer
  import conv_ser_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int K          = DEF_K,
  parameter int OH         = DEF_OH,
  parameter int OW         = DEF_OW
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [0:K*OH*OW*DATA_WIDTH-1]   conv_in,
  input  logic                            start,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [idx_w(K)-1:0]             out_chan,
  output logic [idx_w(OH)-1:0]            out_row,
  output logic [idx_w(OW)-1:0]            out_col,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output conv_ser_state_e                 dbg_state
);

  // Handshake: a word moves on a rising edge where out_valid and out_ready are
  // both high; while out_valid is high and out_ready low, all word outputs hold.

  localparam int NW = K * OH * OW;

  conv_ser_state_e              state_q, state_d;
  logic [0:NW*DATA_WIDTH-1]     shadow_q;
  logic [DATA_WIDTH-1:0]        data_q;
  logic                         capture, xfer, idx_last;
  int                           next_n;

  function automatic logic [DATA_WIDTH-1:0] pass_word(input logic [DATA_WIDTH-1:0] w);
`ifdef CONV_SER_RELU_EN
    return w[DATA_WIDTH-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (out_ready && idx_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == STREAM);
    busy      = (state_q == STREAM);
    done      = (state_q == DONE);
    out_last  = out_valid & idx_last;
    capture   = (state_q == IDLE) & start;
    xfer      = out_valid & out_ready;
    dbg_state = state_q;
  end

  conv_idx_counter #(
    .K  (K),
    .OH (OH),
    .OW (OW)
  ) u_idx (
    .clk   (clk),
    .rst_n (reset),
    .clear (capture),
    .step  (xfer),
    .chan  (out_chan),
    .row   (out_row),
    .col   (out_col),
    .last  (idx_last)
  );

  // Scan order equals linear word order, so the next word is simply n + 1.
  always_comb begin
    next_n = int'(out_chan) * OH * OW + int'(out_row) * OW + int'(out_col) + 1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      data_q   <= '0;
    end else if (capture) begin
      shadow_q <= conv_in;
      data_q   <= pass_word(conv_in[0 +: DATA_WIDTH]);
    end else if (xfer && !idx_last) begin
      data_q   <= pass_word(shadow_q[next_n*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_conv_output_serializer.sv
// Bench for conv_output_serializer: default-size frames plus a 1x1x1 instance.
module tb_conv_output_serializer;
  import conv_ser_pkg::*;

  localparam int DW = 16;
  localparam int K  = 6;
  localparam int OH = 32;
  localparam int OW = 32;
  localparam int N  = K * OH * OW;
  localparam int CW = 3;
  localparam int RW = 5;
  localparam int LW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [0:N*DW-1] conv_in = '0;
  logic            start = 1'b0;
  logic            out_ready = 1'b0;
  logic            out_valid, out_last, busy, done;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_chan;
  logic [RW-1:0]   out_row;
  logic [LW-1:0]   out_col;
  conv_ser_state_e dbg_state;

  logic [0:DW-1]   s_conv_in = '0;
  logic            s_start = 1'b0;
  logic            s_ready = 1'b0;
  logic            s_valid, s_last, s_busy, s_done;
  logic [DW-1:0]   s_data;
  logic            s_chan, s_row, s_col;
  conv_ser_state_e s_state;

  conv_output_serializer #(.DATA_WIDTH(DW), .K(K), .OH(OH), .OW(OW)) u_dut (
    .clk(clk), .reset(reset), .conv_in(conv_in), .start(start), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan), .out_row(out_row),
    .out_col(out_col), .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  conv_output_serializer #(.DATA_WIDTH(DW), .K(1), .OH(1), .OW(1)) u_small (
    .clk(clk), .reset(reset), .conv_in(s_conv_in), .start(s_start), .out_ready(s_ready),
    .out_valid(s_valid), .out_data(s_data), .out_chan(s_chan), .out_row(s_row),
    .out_col(s_col), .out_last(s_last), .busy(s_busy), .done(s_done), .dbg_state(s_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] w);
`ifdef CONV_SER_RELU_EN
    return ($signed(w) < 0) ? '0 : w;
`else
    return w;
`endif
  endfunction

  typedef struct {
    int   n;
    int   chan;
    int   row;
    int   col;
    logic last;
  } idx_vec_t;
  idx_vec_t tbl[8];

  // ---------------- driver tasks ----------------
  task automatic fill_ramp();
    for (int n = 0; n < N; n++) conv_in[n*DW +: DW] = 16'(n);
  endtask

  task automatic fill_random();
    for (int n = 0; n < N; n++) conv_in[n*DW +: DW] = 16'($urandom);
  endtask

  task automatic model_capture();
    exp_q.delete();
    for (int n = 0; n < N; n++) exp_q.push_back(relu_ref(conv_in[n*DW +: DW]));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    model_capture();
    @(negedge clk);
    start = 1'b0;
    chk("latency_valid", out_valid, 1);
    chk("latency_busy", busy, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_idx"}, {out_chan, out_row, out_col}, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, dbg_state, IDLE);
  endtask

  // mode 0: ready held high, 1: random ready, 2: ready pattern 1,0,0,1
  task automatic run_frame(input int mode, input int inject_at, input int abort_at, input bit use_tbl);
    int widx = 0;
    int cyc = 0;
    bit stalled = 0;
    bit inj_pending = 0;
    logic r;
    logic [29:0] snap, prev_snap;
    logic [CW+RW+LW:0] eidx;
    while (widx < N) begin
      if (cyc > 4 * N + 100) begin
        chk("frame_timeout", widx, N);
        out_ready = 1'b0;
        return;
      end
      if (inj_pending) begin
        start = 1'b0;
        inj_pending = 0;
      end
      if (widx == abort_at) begin
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        out_ready = 1'b0;
        return;
      end
      eidx = {CW'(widx / (OH * OW)), RW'((widx / OW) % OH), LW'(widx % OW), (widx == N - 1)};
      snap = {out_data, out_chan, out_row, out_col, out_last};
      chk("valid", out_valid, 1);
      chk("data", out_data, exp_q[0]);
      chk("index", {out_chan, out_row, out_col, out_last}, eidx);
      if (stalled) chk("stall_hold", snap, prev_snap);
      if (use_tbl) begin
        for (int i = 0; i < 8; i++) begin
          if (tbl[i].n == widx) begin
            chk("tbl_data", out_data, tbl[i].n);
            chk("tbl_idx", {out_chan, out_row, out_col, out_last},
                {CW'(tbl[i].chan), RW'(tbl[i].row), LW'(tbl[i].col), tbl[i].last});
          end
        end
      end
      if (widx == inject_at && !inj_pending) begin
        start = 1'b1;
        fill_random();
        inj_pending = 1;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      out_ready = r;
      prev_snap = snap;
      stalled = !r;
      if (r) begin
        void'(exp_q.pop_front());
        widx++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    if (mode == 0) chk("frame_cycles", cyc, N);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_valid", out_valid, 0);
    chk("done_last", out_last, 0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", dbg_state, IDLE);
  endtask

  task automatic small_word(input logic [DW-1:0] w);
    @(negedge clk);
    s_conv_in = w;
    s_start = 1'b1;
    s_ready = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_valid", s_valid, 1);
    chk("s_last", s_last, 1);
    chk("s_data", s_data, relu_ref(w));
    chk("s_idx", {s_chan, s_row, s_col}, 0);
    @(negedge clk);
    chk("s_done", s_done, 1);
    chk("s_done_valid", s_valid, 0);
    chk("s_done_busy", s_busy, 0);
    @(negedge clk);
    chk("s_done_clear", s_done, 0);
    s_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{0,    0, 0,  0,  1'b0};
    tbl[1] = '{31,   0, 0,  31, 1'b0};
    tbl[2] = '{32,   0, 1,  0,  1'b0};
    tbl[3] = '{1023, 0, 31, 31, 1'b0};
    tbl[4] = '{1024, 1, 0,  0,  1'b0};
    tbl[5] = '{2047, 1, 31, 31, 1'b0};
    tbl[6] = '{5120, 5, 0,  0,  1'b0};
    tbl[7] = '{6143, 5, 31, 31, 1'b1};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    chk("s_reset", {s_valid, s_data, s_last, s_busy, s_done}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", out_valid, 0);

    // Ramp frame at full throughput
    fill_ramp();
    pulse_start();
    run_frame(0, -1, -1, 1);

    // Random data, 1,0,0,1 ready pattern, start + conv_in change mid-stream
    fill_random();
    pulse_start();
    run_frame(2, 50, -1, 0);

    // Abort at word 100 with random ready
    fill_random();
    pulse_start();
    run_frame(1, -1, 100, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_idle", out_valid, 0);
    end

    // New frame after the abort starts again from word 0
    fill_ramp();
    pulse_start();
    run_frame(0, -1, -1, 0);

    // Single-word instance, including sign-bit words
    small_word(16'hB4F1);
    small_word(16'h313C);
    small_word(16'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_output_serializer.md
CONV_OUTPUT_SERIALIZER -- requirements
Module: conv_output_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one feature-map word.
REQ-002 SHALL have parameter K, default 6: number of output channels.
REQ-003 SHALL have parameter OH, default 32: output rows per channel.
REQ-004 SHALL have parameter OW, default 32: output columns per channel.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port conv_in, input, [0:K*OH*OW*DATA_WIDTH-1]: flat convolution result. Word n occupies bits [n*DATA_WIDTH +: DATA_WIDTH], with n = k*OH*OW + r*OW + c.
REQ-008 SHALL have port start, input, 1: single-cycle request to capture conv_in and stream it.
REQ-009 SHALL have port out_ready, input, 1: downstream accepts a word.
REQ-010 SHALL have port out_valid, output, 1: out_data holds a valid word.
REQ-011 SHALL have port out_data, output, DATA_WIDTH: current word.
REQ-012 SHALL have ports out_chan, out_row and out_col, outputs, $clog2 of K, OH and OW respectively (minimum 1 bit): indices of the current word.
REQ-013 SHALL have port out_last, output, 1: the current word is n = K*OH*OW-1.
REQ-014 SHALL have port busy, output, 1: high from capture until the DONE state is entered.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the last word transfers.

Function
REQ-016 SHALL implement the states IDLE, STREAM and DONE.
REQ-017 IDLE: on start=1, SHALL capture conv_in into a shadow register, clear the indices to 0 and enter STREAM at the same edge; out_valid SHALL be 1 on the next cycle (one-cycle latency).
REQ-018 SHALL ignore start in STREAM and DONE; the shadow register SHALL NOT change, and changes on conv_in after capture SHALL have no effect.
REQ-019 A transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_chan, out_row, out_col and out_last SHALL hold stable.
REQ-021 Index advance order on each transfer: out_col increments. When out_col=OW-1 it wraps to 0 and out_row increments. When out_row=OH-1 it also wraps to 0 and out_chan increments.
REQ-022 On transfer of the out_last word, SHALL enter DONE, with out_valid=0 on the next cycle.
REQ-023 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 out_data SHALL equal shadow word n for the current indices, registered (no combinational path from out_ready to out_data).
REQ-025 Full frame at out_ready held high: K*OH*OW transfers in consecutive cycles; done asserts K*OH*OW+1 cycles after the capture edge.
REQ-026 K=1, OH=1, OW=1 SHALL work: the first word has out_last=1.

Reset
REQ-027 On reset=0, the following SHALL be 0 asynchronously: state=IDLE, out_valid, out_last, done, busy, the indices, out_data and the shadow register.
REQ-028 Reset asserted mid-STREAM SHALL abort the frame; after release, SHALL wait in IDLE for a new start.

Configuration
REQ-029 Macro CONV_SER_RELU_EN: when defined, any word with MSB (sign bit) = 1 SHALL be output as 0; otherwise the word SHALL pass unchanged.
REQ-030 When CONV_SER_RELU_EN is undefined, words SHALL pass unchanged, with no added logic or latency.

Structure
REQ-031 Package conv_ser_pkg SHALL hold the state enum (IDLE/STREAM/DONE) and index-width helper constants.
REQ-032 The nested chan/row/col counter SHALL be sub-module conv_idx_counter, with inputs step and clear and outputs indices and last.

Verification
REQ-033 Fill conv_in with word n = n (16-bit), pulse start, hold out_ready=1 -> 6144 words 0x0000..0x17FF in order; out_last only on 0x17FF; done one cycle later.
REQ-034 Word 1023 transfers -> out_chan=0, out_row=31, out_col=31; the next word shows out_chan=1, out_row=0, out_col=0.
REQ-035 Toggle out_ready 1,0,0,1 -> outputs frozen during the two stalled cycles; no word lost or duplicated.
REQ-036 Pulse start again mid-stream and change conv_in -> ignored; the stream continues from the original capture.
REQ-037 Assert reset=0 at word 100 -> all outputs 0 immediately; after release, a new start streams from word 0.
REQ-038 With CONV_SER_RELU_EN, word 0xB4F1 -> 0x0000 and word 0x313C -> 0x313C; without the macro, 0xB4F1 -> 0xB4F1.
